lsu_mem_bridge: RTL and testbench
=================================

Name: lsu_mem_bridge

Overview:
Load/store unit for the Memory stage of the 5-stage RV32I pipeline. It replaces the single-cycle data memory with a valid/ready request and response bus towards the DDR3 controller front-end. It generates byte enables and lane-replicated write data, aligns and sign- or zero-extends load data, and stalls the pipeline until each access completes or times out.

Parameters:
DATA_WIDTH, 32, data bus and register width
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 1024, number of cycles in REQ plus WAIT before the access is aborted

Ports:
i_clk  in  1  clock
i_reset_n  in  1  reset
i_req_valid  in  1  Memory-stage instruction is a load or store
i_req_we  in  1  1 = store, 0 = load
i_funct3  in  3  access width and signedness (RV32I encoding)
i_addr  in  ADDR_WIDTH  byte address (ALU result)
i_wr_data  in  DATA_WIDTH  store data from rs2
o_stall  out  1  freeze IF/ID/IE/IM pipeline registers
o_rd_data  out  DATA_WIDTH  extended load data, held until the next completion
o_rd_valid  out  1  one-cycle pulse when an access completes
o_access_fault  out  1  misaligned address or illegal funct3
o_bus_error  out  1  one-cycle pulse on timeout
o_mem_req_valid  out  1  bus request valid
i_mem_req_ready  in  1  bus accepts the request
o_mem_addr  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}
o_mem_we  out  1  bus write
o_mem_be  out  4  byte enables
o_mem_wdata  out  DATA_WIDTH  lane-replicated write data
i_mem_rsp_valid  in  1  response or write acknowledge
i_mem_rsp_data  in  DATA_WIDTH  read word

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low on i_reset_n.
- Reset state: state = IDLE, timeout counter = 0, all outputs 0.
- funct3 encodings:
  - 000 = B, 001 = H, 010 = W for both loads and stores.
  - 100 = BU, 101 = HU for loads only.
  - Any other value is illegal.
- Fault conditions:
  - H or HU access with addr[0] = 1.
  - W access with addr[1:0] != 0.
  - Illegal funct3.
- Fault handling, evaluated in IDLE while i_req_valid = 1: o_access_fault = 1 combinationally, no bus request is issued, o_stall = 0, o_rd_valid = 0, and the FSM stays in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on a legal i_req_valid, register addr/we/funct3/wdata and go to REQ. o_stall = 1 combinationally in this same cycle.
  - REQ: o_mem_req_valid = 1 with a payload that stays stable until i_mem_req_ready = 1, then go to WAIT. If ready is high in the first REQ cycle, the request takes one cycle.
  - WAIT: on i_mem_rsp_valid, capture i_mem_rsp_data (stores ignore the data) and go to DONE. Responses seen in IDLE or REQ are ignored.
  - DONE: o_stall = 0, o_rd_valid = 1 for exactly one cycle, then go to IDLE. i_req_valid in DONE never re-issues, because it belongs to the instruction that is retiring.
- o_stall = (IDLE and legal i_req_valid) or REQ or WAIT.
- Minimum load/store latency is 3 stall cycles (IDLE, REQ, WAIT), with DONE as the release cycle.
- Store byte enables and write data:
  - SB: be = 4'b0001 << addr[1:0], byte replicated on all four lanes.
  - SH: be = 4'b0011 (addr[1] = 0) or 4'b1100 (addr[1] = 1), halfword replicated on both halves.
  - SW: be = 4'b1111.
- Loads drive be = 4'b1111. The selected lane is extracted and then:
  - LB and LH: sign-extended.
  - LBU and LHU: zero-extended.
  - LW: passed through.
- Timeout: the counter clears on entering REQ and increments each cycle in REQ and WAIT. When it reaches TIMEOUT_CYCLES-1, the FSM goes to DONE with o_rd_data = 0 and o_bus_error pulses in the DONE cycle. o_mem_req_valid drops immediately.
- Mid-operation reset: the FSM returns to IDLE asynchronously and o_mem_req_valid drops asynchronously. Any later stale response is ignored because the FSM is in IDLE.

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum lsu_state_t, and a byte-enable function.
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension, with inputs rsp_data, addr[1:0] and funct3.

Test Plan:
- LW at 0x10, ready = 1 at once, rsp in the next cycle with data 0xDEADBEEF -> stall high for 3 cycles, rd_valid pulse, rd_data = 0xDEADBEEF.
- LB at 0x13, rsp 0x80FF_FFFF -> rd_data = 0xFFFFFF80. Same access with LBU -> rd_data = 0x00000080.
- SH at 0x22 with wr_data 0x0000ABCD -> mem_addr 0x20, be 1100, wdata 0xABCDABCD, mem_we = 1.
- LW at 0x06, and separately funct3 = 011 -> access_fault = 1, no mem_req_valid, stall = 0.
- Ready held low for 5 cycles -> payload stable throughout. With no rsp for TIMEOUT_CYCLES = 8 -> bus_error pulse, rd_data = 0, stall released.
- Reset asserted in WAIT, then rsp_valid arrives after reset release -> req_valid drops at once, no rd_valid, FSM stays in IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store bridge: funct3 codes, FSM states,
// byte-enable generation and access-legality checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Loads always fetch the full word; only stores narrow the enables.
  function automatic logic [3:0] lsu_byte_en(input logic we, input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b1111;
    if (we) begin
      case (funct3)
        F3_B:    be = 4'b0001 << addr_lo;
        F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic lsu_fault(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic flt;
    case (funct3)
      F3_B:    flt = 1'b0;
      F3_BU:   flt = we;
      F3_H:    flt = addr_lo[0];
      F3_HU:   flt = we | addr_lo[0];
      F3_W:    flt = |addr_lo;
      default: flt = 1'b1;
    endcase
    return flt;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic [1:0]            addr,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rsp_data[7:0];
      2'd1:    byte_sel = rsp_data[15:8];
      2'd2:    byte_sel = rsp_data[23:16];
      default: byte_sel = rsp_data[31:24];
    endcase
    half_sel = addr[1] ? rsp_data[31:16] : rsp_data[15:0];

    case (funct3)
      F3_B:    load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_H:    load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_data = rsp_data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Memory-stage load/store unit: turns one pipeline access into a valid/ready bus
// request plus response, stalling the pipeline until completion or timeout.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no access in flight; legal request is latched here
//   REQ     | bus request presented, payload held until accepted
//   WAIT    | request accepted, waiting for read data / write ack
//   DONE    | one-cycle release: rd_valid (and bus_error on timeout)
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_access_fault,
  output logic                  o_bus_error,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rsp_data
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t            state, state_nx;
  logic [CNT_W-1:0]      tmo_cnt;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic                  req_fault;
  logic                  req_go;
  logic                  tmo_hit;
  logic                  bus_err_set;
  logic                  rsp_take;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] load_data;

  assign req_fault = lsu_fault(i_req_we, i_funct3, i_addr[1:0]);
  assign req_go    = (state == ST_IDLE) && i_req_valid && !req_fault;
  assign tmo_hit   = tmo_cnt >= TMO_LAST;
  assign rsp_take  = (state == ST_WAIT) && i_mem_rsp_valid;

  // A handshake or response in the last counted cycle still wins over the abort.
  assign bus_err_set = ((state == ST_REQ)  && !i_mem_req_ready && tmo_hit) ||
                       ((state == ST_WAIT) && !i_mem_rsp_valid && tmo_hit);

  assign o_stall         = req_go || (state == ST_REQ) || (state == ST_WAIT);
  assign o_access_fault  = (state == ST_IDLE) && i_req_valid && req_fault;
  assign o_mem_req_valid = (state == ST_REQ);
  assign o_rd_valid      = (state == ST_DONE);

  always_comb begin
    case (i_funct3)
      F3_B:    wdata_rep = {4{i_wr_data[7:0]}};
      F3_H:    wdata_rep = {2{i_wr_data[15:0]}};
      default: wdata_rep = i_wr_data;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req_go) state_nx = ST_REQ;
      ST_REQ:  if (i_mem_req_ready) state_nx = ST_WAIT;
               else if (tmo_hit)    state_nx = ST_DONE;
      ST_WAIT: if (i_mem_rsp_valid) state_nx = ST_DONE;
               else if (tmo_hit)    state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rsp_data  (i_mem_rsp_data),
    .addr      (addr_lo_q),
    .funct3    (funct3_q),
    .load_data (load_data)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
      o_rd_data   <= '0;
      o_bus_error <= 1'b0;
    end else begin
      state       <= state_nx;
      o_bus_error <= bus_err_set;

      if (req_go)
        tmo_cnt <= '0;
      else if ((state == ST_REQ) || (state == ST_WAIT))
        tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (req_go) begin
        funct3_q    <= i_funct3;
        addr_lo_q   <= i_addr[1:0];
        o_mem_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
        o_mem_we    <= i_req_we;
        o_mem_be    <= lsu_byte_en(i_req_we, i_funct3, i_addr[1:0]);
        o_mem_wdata <= wdata_rep;
      end

      // Store acks carry no data, so a completing store (or abort) leaves zero here.
      if (rsp_take)
        o_rd_data <= o_mem_we ? '0 : load_data;
      else if (bus_err_set)
        o_rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Self-checking bench for lsu_mem_bridge: per-transaction timeline model with random
// bus delays, a per-cycle compare process, and a few literal anchor checks.
module tb_lsu_mem_bridge;

  localparam int T = 8;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        i_req_we = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        o_stall;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_access_fault;
  logic        o_bus_error;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready = 1'b0;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rsp_valid = 1'b0;
  logic [31:0] i_mem_rsp_data = '0;

  always #5 i_clk = ~i_clk;

  lsu_mem_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_req_valid     (i_req_valid),
    .i_req_we        (i_req_we),
    .i_funct3        (i_funct3),
    .i_addr          (i_addr),
    .i_wr_data       (i_wr_data),
    .o_stall         (o_stall),
    .o_rd_data       (o_rd_data),
    .o_rd_valid      (o_rd_valid),
    .o_access_fault  (o_access_fault),
    .o_bus_error     (o_bus_error),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_addr      (o_mem_addr),
    .o_mem_we        (o_mem_we),
    .o_mem_be        (o_mem_be),
    .o_mem_wdata     (o_mem_wdata),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rsp_data  (i_mem_rsp_data)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic        exp_stall = 0, exp_fault = 0, exp_mreq = 0, exp_rdv = 0, exp_berr = 0;
  logic        exp_we = 0;
  logic [31:0] exp_rd = '0, exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;

  logic [31:0] seen_rd, seen_be, seen_wdata, seen_addr;
  logic        seen_we, seen_fault, seen_mreq, seen_berr;
  int          stall_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge i_clk) begin
    #2;
    if (chk_en) begin
      check("stall",        32'(o_stall),         32'(exp_stall));
      check("access_fault", 32'(o_access_fault),  32'(exp_fault));
      check("mem_req_valid",32'(o_mem_req_valid), 32'(exp_mreq));
      check("rd_valid",     32'(o_rd_valid),      32'(exp_rdv));
      check("bus_error",    32'(o_bus_error),     32'(exp_berr));
      check("rd_data",      o_rd_data,            exp_rd);
      if (exp_mreq) begin
        check("mem_addr", o_mem_addr,      exp_addr);
        check("mem_we",   32'(o_mem_we),   32'(exp_we));
        check("mem_be",   32'(o_mem_be),   32'(exp_be));
        if (exp_we) check("mem_wdata", o_mem_wdata, exp_wdata);
      end
    end
  end

  // ---- reference model (access rules, not the RTL structure) ----
  function automatic bit m_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int size;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    size  = 1 << f3[1:0];
    return !legal || ((int'(a[1:0]) % size) != 0);
  endfunction

  function automatic logic [3:0] m_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = 1 << f3[1:0];
    if (!we || size >= 4) return 4'hF;
    return 4'(((1 << size) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int size;
    size = 1 << f3[1:0];
    if (size == 1) return 32'(wd[7:0]) * 32'h0101_0101;
    if (size == 2) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    longint v;
    v = longint'(w >> (8 * int'(a[1:0])));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v -= 256;   end
      3'd4: v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v -= 65536; end
      3'd5: v = v % 65536;
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  task automatic set_exp(input logic st, input logic fa, input logic mr, input logic rv,
                         input logic be_err);
    exp_stall = st; exp_fault = fa; exp_mreq = mr; exp_rdv = rv; exp_berr = be_err;
  endtask

  task automatic scramble();
    i_addr = $urandom; i_wr_data = $urandom; i_funct3 = 3'($urandom);
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_req_valid = 1'b0;
      i_mem_req_ready = 1'($urandom); i_mem_rsp_valid = 1'($urandom); i_mem_rsp_data = $urandom;
      set_exp(0, 0, 0, 0, 0);
    end
  endtask

  // One pipeline access; the bus answers ready after rdy_dly REQ cycles and
  // responds rsp_dly WAIT cycles later (never if no_rsp); abort after T cycles.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                         input bit no_rsp, input logic [31:0] rsp_word);
    bit flt, err, got;
    int e, j;
    logic [31:0] res;
    flt = m_fault(we, f3, addr);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = we; i_funct3 = f3; i_addr = addr; i_wr_data = wdata;
    i_mem_req_ready = 1'($urandom); i_mem_rsp_valid = 1'($urandom); i_mem_rsp_data = $urandom;
    exp_addr = addr & 32'hFFFF_FFFC; exp_we = we;
    exp_be = m_be(we, f3, addr); exp_wdata = m_wdata(f3, wdata);
    set_exp(!flt, flt, 0, 0, 0);
    #3;
    stall_seen = int'(o_stall); seen_fault = o_access_fault; seen_mreq = o_mem_req_valid;
    if (flt) return;

    e = 0; err = 1'b0;
    forever begin
      @(negedge i_clk);
      scramble();
      i_mem_req_ready = (e >= rdy_dly);
      i_mem_rsp_valid = 1'($urandom); i_mem_rsp_data = $urandom;
      set_exp(1, 0, 1, 0, 0);
      #3;
      stall_seen += int'(o_stall);
      seen_be = 32'(o_mem_be); seen_wdata = o_mem_wdata; seen_addr = o_mem_addr; seen_we = o_mem_we;
      e++;
      if (i_mem_req_ready) break;
      if (e == T) begin err = 1'b1; break; end
    end

    j = 0;
    while (!err) begin
      @(negedge i_clk);
      scramble();
      i_mem_req_ready = 1'($urandom);
      got = !no_rsp && (j >= rsp_dly);
      i_mem_rsp_valid = got;
      i_mem_rsp_data  = got ? rsp_word : $urandom;
      set_exp(1, 0, 0, 0, 0);
      #3;
      stall_seen += int'(o_stall);
      if (got) break;
      if (e >= T - 1) err = 1'b1;
      e++; j++;
    end

    res = (err || we) ? 32'h0 : m_load(f3, addr, rsp_word);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'($urandom); scramble();
    i_mem_req_ready = 1'($urandom); i_mem_rsp_valid = 1'($urandom); i_mem_rsp_data = $urandom;
    exp_rd = res;
    set_exp(0, 0, 0, 1, err);
    #3;
    stall_seen += int'(o_stall); seen_rd = o_rd_data; seen_berr = o_bus_error;
  endtask

  task automatic reset_mid(input bit in_wait);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h40;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0;
    exp_addr = 32'h40; exp_we = 1'b0; exp_be = 4'hF;
    set_exp(1, 0, 0, 0, 0);
    @(negedge i_clk);
    i_mem_req_ready = in_wait;
    set_exp(1, 0, 1, 0, 0);
    if (in_wait) begin
      @(negedge i_clk);
      i_mem_req_ready = 1'b0;
      set_exp(1, 0, 0, 0, 0);
    end
    @(negedge i_clk);
    i_reset_n = 1'b0; i_req_valid = 1'b0; i_mem_req_ready = 1'b0;
    exp_rd = '0;
    set_exp(0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h1234_5678;
    @(negedge i_clk);
    i_mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit we, nr;
    logic [2:0] f3;
    logic [31:0] a;
    int size, rd;

    chk_en = 1'b1;
    drive_idle(2);
    check("reset_rd_data", o_rd_data, 32'h0);
    i_reset_n = 1'b1;
    drive_idle(1);

    run_txn(0, 3'd2, 32'h10, 32'h0, 0, 0, 0, 32'hDEAD_BEEF);
    check("lw_rd_data", seen_rd, 32'hDEAD_BEEF);
    check("lw_stall_cycles", 32'(stall_seen), 32'd3);

    run_txn(0, 3'd0, 32'h13, 32'h0, 0, 1, 0, 32'h80FF_FFFF);
    check("lb_rd_data", seen_rd, 32'hFFFF_FF80);
    run_txn(0, 3'd4, 32'h13, 32'h0, 1, 0, 0, 32'h80FF_FFFF);
    check("lbu_rd_data", seen_rd, 32'h0000_0080);

    run_txn(1, 3'd1, 32'h22, 32'h0000_ABCD, 0, 0, 0, 32'h5555_5555);
    check("sh_addr", seen_addr, 32'h20);
    check("sh_be", seen_be, 32'hC);
    check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    check("sh_we", 32'(seen_we), 32'd1);

    run_txn(0, 3'd2, 32'h06, 32'h0, 0, 0, 0, 32'h0);
    check("lw_mis_fault", 32'(seen_fault), 32'd1);
    check("lw_mis_no_req", 32'(seen_mreq), 32'd0);
    check("lw_mis_stall", 32'(stall_seen), 32'd0);
    run_txn(0, 3'd3, 32'h08, 32'h0, 0, 0, 0, 32'h0);
    check("f3_011_fault", 32'(seen_fault), 32'd1);
    drive_idle(1);

    run_txn(0, 3'd2, 32'h100, 32'h0, 5, 0, 0, 32'hCAFE_F00D);
    check("slow_ready_rd", seen_rd, 32'hCAFE_F00D);
    check("slow_ready_stall", 32'(stall_seen), 32'd8);

    run_txn(0, 3'd2, 32'h104, 32'h0, 0, 0, 1, 32'h0);
    check("tmo_rsp_rd", seen_rd, 32'h0);
    check("tmo_rsp_err", 32'(seen_berr), 32'd1);
    check("tmo_rsp_stall", 32'(stall_seen), 32'd9);
    run_txn(0, 3'd5, 32'h42, 32'h0, 0, 0, 0, 32'h9000_0000);
    check("lhu_rd", seen_rd, 32'h0000_9000);
    run_txn(1, 3'd2, 32'h108, 32'h1111_2222, 1000, 0, 0, 32'h0);
    check("tmo_rdy_err", 32'(seen_berr), 32'd1);
    check("tmo_rdy_stall", 32'(stall_seen), 32'd9);

    reset_mid(1'b0);
    reset_mid(1'b1);
    drive_idle(1);

    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
        size = 1 << f3[1:0];
        a = a & ~32'(size - 1);
      end
      rd = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 3));
      nr = ($urandom_range(0, 9) == 0);
      run_txn(we, f3, a, $urandom, rd, int'($urandom_range(0, 2)), nr, $urandom);
      drive_idle(int'($urandom_range(0, 2)));
    end

    drive_idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
